// File: rtl/wave_seq_ctrl.sv
// -----------------------------------------------------------------------------
// wave_seq_ctrl
//   Sequencer and output selector for the lab waveform generators
//   (sine, square, triangle, sine-square). It produces the step-rate
//   enable and the in-phase clear for the generators, and drives a
//   registered mux that picks one generator. New configuration is taken
//   through a valid/ready handshake and only takes effect on a waveform
//   period boundary, so the output never switches mid-period.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-low
//   cfg_valid     configuration offered
//   cfg_ready     configuration can be accepted
//   cfg_wave      waveform select: 0 sine, 1 square, 2 triangle, 3 sine-square
//   cfg_div       tick period minus one
//   cfg_burst     periods to play, 0 = continuous
//   start         begin playback (sampled in IDLE only)
//   stop          graceful stop request (finish the current period)
//   wave_in0..3   generator samples
//   gen_en        one-cycle step enable to the generators
//   gen_clr       one-cycle synchronous clear to the generators
//   wave_out      selected sample, registered (1 cycle latency)
//   period_done   one-cycle pulse per completed period
//   busy          high in every state except IDLE
//   o_dbg_state   current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 FINISH)
// -----------------------------------------------------------------------------
module wave_seq_ctrl #(
    parameter int DIV_W        = 16,
    parameter int BURST_W      = 8,
    parameter int PERIOD_STEPS = 402
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_wave,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         wave_in0,
    input  logic [7:0]         wave_in1,
    input  logic [7:0]         wave_in2,
    input  logic [7:0]         wave_in3,
    output logic               gen_en,
    output logic               gen_clr,
    output logic [7:0]         wave_out,
    output logic               period_done,
    output logic               busy,
    output logic [1:0]         o_dbg_state
);

    localparam int STEP_W = (PERIOD_STEPS > 2) ? $clog2(PERIOD_STEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PERIOD_STEPS - 1);
    localparam logic [7:0] WAVE_REST = 8'h7F;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]         r_state;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [STEP_W-1:0]  r_step_cnt;
    logic [BURST_W-1:0] r_per_cnt;

    logic [1:0]         r_act_wave;
    logic [DIV_W-1:0]   r_act_div;
    logic [BURST_W-1:0] r_act_burst;
    logic [1:0]         r_sh_wave;
    logic [DIV_W-1:0]   r_sh_div;
    logic [BURST_W-1:0] r_sh_burst;
    logic               r_cfg_loaded;
    logic               r_pending;

    logic [7:0]         r_wave_out;
    logic               r_period_done;

    logic               w_counting;
    logic               w_xfer;
    logic               w_tick;
    logic               w_boundary;
    logic               w_burst_end;
    logic               w_next_counting;
    logic [1:0]         w_state_nxt;
    logic [7:0]         w_sel;

    // Handshake: a transfer happens on a rising edge where cfg_valid and
    // cfg_ready are both high. cfg_ready is always high in IDLE (the word goes
    // straight into the active config); elsewhere it is high only while the
    // single shadow slot is empty. The offer may be held with cfg_valid
    // high for any number of cycles while cfg_ready is low; nothing changes.
    assign cfg_ready  = (r_state == ST_IDLE) || !r_pending;
    assign w_xfer     = cfg_valid && cfg_ready;

    assign w_counting  = (r_state == ST_RUN) || (r_state == ST_FINISH);
    assign w_tick      = w_counting && (r_div_cnt == r_act_div);
    assign w_boundary  = w_tick && (r_step_cnt == STEP_LAST);
    assign w_burst_end = (r_act_burst != '0) &&
                         (({1'b0, r_per_cnt} + 1'b1) == {1'b0, r_act_burst});
    assign w_next_counting = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FINISH);

    always_comb begin
        w_sel = wave_in0;
        case (r_act_wave)
            2'd0:    w_sel = wave_in0;
            2'd1:    w_sel = wave_in1;
            2'd2:    w_sel = wave_in2;
            default: w_sel = wave_in3;
        endcase
    end

    // Boundary actions in priority order: burst complete, graceful finish,
    // pending reconfiguration, otherwise keep playing. A stop request only
    // turns RUN into FINISH when the cycle would otherwise stay in RUN, so a
    // stop that coincides with a drop to IDLE or a reload is not acted on.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && (r_cfg_loaded || w_xfer)) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_FINISH: begin
                if (w_boundary) begin
                    if (w_burst_end || (r_state == ST_FINISH)) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_pending) begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN) && stop) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_step_cnt <= '0;
            r_per_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_LOAD) begin
                r_div_cnt  <= '0;
                r_step_cnt <= '0;
                r_per_cnt  <= '0;
            end else if (w_counting) begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    if (w_boundary) begin
                        r_step_cnt <= '0;
                        if (w_next_counting) begin
                            // plain continuation: count the period, saturating
                            if (!(&r_per_cnt)) begin
                                r_per_cnt <= r_per_cnt + 1'b1;
                            end
                        end else begin
                            r_per_cnt <= '0;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
        end
    end

    // Active and shadow configuration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_act_wave   <= '0;
            r_act_div    <= '0;
            r_act_burst  <= '0;
            r_sh_wave    <= '0;
            r_sh_div     <= '0;
            r_sh_burst   <= '0;
            r_cfg_loaded <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (r_state == ST_IDLE) begin
                    // a word accepted in IDLE supersedes anything still pending
                    r_act_wave   <= cfg_wave;
                    r_act_div    <= cfg_div;
                    r_act_burst  <= cfg_burst;
                    r_cfg_loaded <= 1'b1;
                    r_pending    <= 1'b0;
                end else begin
                    r_sh_wave  <= cfg_wave;
                    r_sh_div   <= cfg_div;
                    r_sh_burst <= cfg_burst;
                    r_pending  <= 1'b1;
                end
            end else if (r_pending && (w_state_nxt == ST_LOAD)) begin
                // reload either at a period boundary or at the next start
                r_act_wave  <= r_sh_wave;
                r_act_div   <= r_sh_div;
                r_act_burst <= r_sh_burst;
                r_pending   <= 1'b0;
            end
        end
    end

    // Output register: follows the selected generator only while playback
    // continues across the edge; rests at mid-scale otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wave_out    <= WAVE_REST;
            r_period_done <= 1'b0;
        end else begin
            r_wave_out    <= (w_counting && w_next_counting) ? w_sel : WAVE_REST;
            r_period_done <= w_boundary;
        end
    end

    assign gen_en      = w_tick;
    assign gen_clr     = (r_state == ST_LOAD);
    assign busy        = (r_state != ST_IDLE);
    assign wave_out    = r_wave_out;
    assign period_done = r_period_done;
    assign o_dbg_state = r_state;

endmodule
